// File: rtl/mem_master_if.sv
// Bundle of the command, response and memory-bus signals around mem_master.
// master = the mem_master side, slave = the traffic source / memory side.
interface mem_master_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;
  logic              mem_rst;
  logic              mem_enable;
  logic              mem_rd_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;
  logic              busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, mem_rd_data,
    output cmd_ready, rsp_valid, rsp_addr, rsp_data,
           mem_rst, mem_enable, mem_rd_wr, mem_addr, mem_wr_data, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, mem_rd_data,
    input  cmd_ready, rsp_valid, rsp_addr, rsp_data,
           mem_rst, mem_enable, mem_rd_wr, mem_addr, mem_wr_data, busy
  );
endinterface

// File: rtl/mem_master.sv
// Bus initiator for the small enable/rd_wr memory: one access per command,
// single outstanding read with a valid/ready response, memory reset sequencing.
module mem_master #(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1,
  parameter int RST_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  mem_master_if.master bus
);
  localparam logic [1:0] S_RESET_HOLD = 2'd0;
  localparam logic [1:0] S_IDLE       = 2'd1;
  localparam logic [1:0] S_READ_WAIT  = 2'd2;
  localparam logic [1:0] S_RSP_HOLD   = 2'd3;

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int LCW = $clog2(RD_LATENCY + 1);

  logic [1:0]        state_q, state_d;
  logic [RCW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [LCW-1:0]    lat_cnt_q, lat_cnt_d;
  logic              mem_rst_q, mem_rst_d;
  logic              mem_enable_q, mem_enable_d;
  logic              mem_rd_wr_q, mem_rd_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wr_data_q, mem_wr_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    lat_cnt_d     = lat_cnt_q;
    mem_rst_d     = mem_rst_q;
    mem_enable_d  = 1'b0;
    mem_rd_wr_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_addr_d    = rsp_addr_q;
    rsp_data_d    = rsp_data_q;

    case (state_q)
      S_RESET_HOLD: begin
        if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
          state_d   = S_IDLE;
          mem_rst_d = 1'b0;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end
      S_IDLE: begin
        if (bus.cmd_valid) begin
          mem_enable_d = 1'b1;
          mem_rd_wr_d  = bus.cmd_write;
          mem_addr_d   = bus.cmd_addr;
          if (bus.cmd_write) begin
            mem_wr_data_d = bus.cmd_wdata;
          end else begin
            state_d    = S_READ_WAIT;
            lat_cnt_d  = LCW'(RD_LATENCY);
            rsp_addr_d = bus.cmd_addr;
          end
        end
      end
      // Counter is loaded with RD_LATENCY, so capture lands RD_LATENCY edges
      // after the memory samples the read.
      S_READ_WAIT: begin
        if (lat_cnt_q == '0) begin
          rsp_data_d  = bus.mem_rd_data;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP_HOLD;
        end else begin
          lat_cnt_d = lat_cnt_q - LCW'(1);
        end
      end
      S_RSP_HOLD: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_RESET_HOLD;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_RESET_HOLD;
      rst_cnt_q     <= '0;
      lat_cnt_q     <= '0;
      mem_rst_q     <= 1'b1;
      mem_enable_q  <= 1'b0;
      mem_rd_wr_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_addr_q    <= '0;
      rsp_data_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      lat_cnt_q     <= lat_cnt_d;
      mem_rst_q     <= mem_rst_d;
      mem_enable_q  <= mem_enable_d;
      mem_rd_wr_q   <= mem_rd_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_addr_q    <= rsp_addr_d;
      rsp_data_q    <= rsp_data_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.cmd_ready   = (state_q == S_IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_addr    = rsp_addr_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.mem_rst     = mem_rst_q;
  assign bus.mem_enable  = mem_enable_q;
  assign bus.mem_rd_wr   = mem_rd_wr_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master: two instances (RD_LATENCY 1 and 3) each
// driving a behavioural 8x8 synchronous memory.
module tb_mem_master;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  mem_master_if #(.ADDR_W(3), .DATA_W(8)) bus0 ();
  mem_master_if #(.ADDR_W(3), .DATA_W(8)) bus1 ();

  mem_master #(.ADDR_W(3), .DATA_W(8), .RD_LATENCY(1), .RST_CYCLES(2))
    dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
  mem_master #(.ADDR_W(3), .DATA_W(8), .RD_LATENCY(3), .RST_CYCLES(2))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

  logic [7:0] mem0 [8];
  logic [7:0] mem1 [8];

  always @(posedge clk) begin
    if (bus0.mem_enable) begin
      if (bus0.mem_rd_wr) mem0[bus0.mem_addr] <= bus0.mem_wr_data;
      else                bus0.mem_rd_data    <= mem0[bus0.mem_addr];
    end
    if (bus1.mem_enable) begin
      if (bus1.mem_rd_wr) mem1[bus1.mem_addr] <= bus1.mem_wr_data;
      else                bus1.mem_rd_data    <= mem1[bus1.mem_addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    total++; if (bus0.mem_rst !== 1'b1) $display("FAIL reset_mem_rst got %0b want 1", bus0.mem_rst); else passed++;
    total++; if (bus0.cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready got %0b want 0", bus0.cmd_ready); else passed++;
    total++; if ({bus0.rsp_valid, bus0.mem_enable, bus0.mem_rd_wr, bus0.busy} !== 4'b0000)
      $display("FAIL reset_flags got %b want 0000", {bus0.rsp_valid, bus0.mem_enable, bus0.mem_rd_wr, bus0.busy}); else passed++;
    total++; if ({bus0.mem_addr, bus0.mem_wr_data, bus0.rsp_addr, bus0.rsp_data} !== 22'd0)
      $display("FAIL reset_data got %h want 0", {bus0.mem_addr, bus0.mem_wr_data, bus0.rsp_addr, bus0.rsp_data}); else passed++;
    rst = 1'b0;
    tick();
    total++; if ({bus0.mem_rst, bus0.cmd_ready, bus0.busy} !== 3'b101)
      $display("FAIL release_edge1 got mem_rst/cmd_ready/busy=%b want 101", {bus0.mem_rst, bus0.cmd_ready, bus0.busy}); else passed++;
    tick();
    total++; if ({bus0.mem_rst, bus0.cmd_ready, bus0.busy} !== 3'b010)
      $display("FAIL release_edge2 got mem_rst/cmd_ready/busy=%b want 010", {bus0.mem_rst, bus0.cmd_ready, bus0.busy}); else passed++;
    total++; if ({bus1.mem_rst, bus1.cmd_ready} !== 2'b01)
      $display("FAIL release_dut1 got mem_rst/cmd_ready=%b want 01", {bus1.mem_rst, bus1.cmd_ready}); else passed++;
  endtask

  task automatic test_write_read;
    bus0.cmd_valid = 1'b1; bus0.cmd_write = 1'b1; bus0.cmd_addr = 3'd5; bus0.cmd_wdata = 8'hA5;
    bus0.rsp_ready = 1'b1;
    tick();
    total++; if ({bus0.mem_enable, bus0.mem_rd_wr, bus0.mem_addr, bus0.mem_wr_data, bus0.cmd_ready} !== {2'b11, 3'd5, 8'hA5, 1'b1})
      $display("FAIL wr_issue got en/rw/addr/data/rdy=%b/%b/%0d/%h/%b want 1/1/5/a5/1",
               bus0.mem_enable, bus0.mem_rd_wr, bus0.mem_addr, bus0.mem_wr_data, bus0.cmd_ready); else passed++;
    bus0.cmd_write = 1'b0; bus0.cmd_wdata = 8'h00;
    tick();
    bus0.cmd_valid = 1'b0;
    total++; if ({bus0.mem_enable, bus0.mem_rd_wr, bus0.mem_addr, bus0.cmd_ready, bus0.busy} !== {2'b10, 3'd5, 2'b01})
      $display("FAIL rd_issue got en/rw/addr/rdy/busy=%b/%b/%0d/%b/%b want 1/0/5/0/1",
               bus0.mem_enable, bus0.mem_rd_wr, bus0.mem_addr, bus0.cmd_ready, bus0.busy); else passed++;
    tick();
    total++; if ({bus0.mem_enable, bus0.rsp_valid} !== 2'b00)
      $display("FAIL rd_wait got en/rsp_valid=%b want 00", {bus0.mem_enable, bus0.rsp_valid}); else passed++;
    tick();
    total++; if ({bus0.rsp_valid, bus0.rsp_addr, bus0.rsp_data} !== {1'b1, 3'd5, 8'hA5})
      $display("FAIL rd_rsp got valid/addr/data=%b/%0d/%h want 1/5/a5", bus0.rsp_valid, bus0.rsp_addr, bus0.rsp_data); else passed++;
    tick();
    total++; if ({bus0.rsp_valid, bus0.cmd_ready} !== 2'b01)
      $display("FAIL rd_handshake got valid/rdy=%b want 01", {bus0.rsp_valid, bus0.cmd_ready}); else passed++;
  endtask

  task automatic test_backpressure;
    bus0.rsp_ready = 1'b0;
    bus0.cmd_valid = 1'b1; bus0.cmd_write = 1'b0; bus0.cmd_addr = 3'd3;
    tick();
    bus0.cmd_valid = 1'b0;
    repeat (2) tick();
    total++; if ({bus0.rsp_valid, bus0.rsp_data, bus0.rsp_addr} !== {1'b1, 8'h3C, 3'd3})
      $display("FAIL bp_rsp got valid/data/addr=%b/%h/%0d want 1/3c/3", bus0.rsp_valid, bus0.rsp_data, bus0.rsp_addr); else passed++;
    bus0.cmd_valid = 1'b1; // must not be accepted while the response is held
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if ({bus0.rsp_valid, bus0.rsp_data, bus0.cmd_ready, bus0.mem_enable} !== {1'b1, 8'h3C, 2'b00})
        $display("FAIL bp_hold%0d got valid/data/rdy/en=%b/%h/%b/%b want 1/3c/0/0",
                 i, bus0.rsp_valid, bus0.rsp_data, bus0.cmd_ready, bus0.mem_enable); else passed++;
    end
    bus0.cmd_valid = 1'b0;
    bus0.rsp_ready = 1'b1;
    tick();
    total++; if ({bus0.rsp_valid, bus0.cmd_ready, bus0.busy} !== 3'b010)
      $display("FAIL bp_release got valid/rdy/busy=%b want 010", {bus0.rsp_valid, bus0.cmd_ready, bus0.busy}); else passed++;
  endtask

  task automatic test_reset_mid_read;
    bus0.cmd_valid = 1'b1; bus0.cmd_write = 1'b0; bus0.cmd_addr = 3'd5;
    tick();
    bus0.cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++; if ({bus0.mem_enable, bus0.mem_rst, bus0.cmd_ready} !== 3'b010)
      $display("FAIL midrst_async got en/mem_rst/rdy=%b want 010", {bus0.mem_enable, bus0.mem_rst, bus0.cmd_ready}); else passed++;
    repeat (3) begin
      tick();
      total++; if (bus0.rsp_valid !== 1'b0) $display("FAIL midrst_no_rsp got %b want 0", bus0.rsp_valid); else passed++;
    end
    rst = 1'b0;
    repeat (2) tick();
    total++; if (bus0.rsp_valid !== 1'b0 || bus0.cmd_ready !== 1'b1)
      $display("FAIL midrst_release got valid/rdy=%b%b want 01", bus0.rsp_valid, bus0.cmd_ready); else passed++;
    bus0.cmd_valid = 1'b1; bus0.cmd_addr = 3'd5;
    tick();
    bus0.cmd_valid = 1'b0;
    repeat (2) tick();
    total++; if ({bus0.rsp_valid, bus0.rsp_addr, bus0.rsp_data} !== {1'b1, 3'd5, 8'hA5})
      $display("FAIL midrst_reread got valid/addr/data=%b/%0d/%h want 1/5/a5", bus0.rsp_valid, bus0.rsp_addr, bus0.rsp_data); else passed++;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    bus0.cmd_valid = 1'b1; bus0.cmd_write = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = 8'h10 + 8'(i);
      bus0.cmd_addr = 3'(i); bus0.cmd_wdata = d;
      tick();
      total++; if ({bus0.mem_enable, bus0.mem_rd_wr, bus0.mem_addr, bus0.mem_wr_data, bus0.cmd_ready, bus0.busy} !== {2'b11, 3'(i), d, 2'b10})
        $display("FAIL b2b_wr%0d got en/rw/addr/data/rdy/busy=%b/%b/%0d/%h/%b/%b want 1/1/%0d/%h/1/0",
                 i, bus0.mem_enable, bus0.mem_rd_wr, bus0.mem_addr, bus0.mem_wr_data, bus0.cmd_ready, bus0.busy, i, d); else passed++;
    end
    bus0.cmd_valid = 1'b0;
    tick();
    total++; if ({bus0.mem_enable, bus0.mem_rd_wr, bus0.mem_addr, bus0.mem_wr_data} !== {2'b00, 3'd7, 8'h17})
      $display("FAIL b2b_idle got en/rw/addr/data=%b/%b/%0d/%h want 0/0/7/17",
               bus0.mem_enable, bus0.mem_rd_wr, bus0.mem_addr, bus0.mem_wr_data); else passed++;
  endtask

  task automatic test_latency3;
    bus1.rsp_ready = 1'b1;
    bus1.cmd_valid = 1'b1; bus1.cmd_write = 1'b0; bus1.cmd_addr = 3'd1;
    tick();
    bus1.cmd_valid = 1'b0;
    total++; if ({bus1.mem_enable, bus1.mem_rd_wr, bus1.mem_addr} !== {2'b10, 3'd1})
      $display("FAIL lat3_issue got en/rw/addr=%b/%b/%0d want 1/0/1", bus1.mem_enable, bus1.mem_rd_wr, bus1.mem_addr); else passed++;
    for (int e = 1; e <= 3; e++) begin
      tick();
      total++; if (bus1.rsp_valid !== 1'b0) $display("FAIL lat3_early_E%0d got %b want 0", e, bus1.rsp_valid); else passed++;
    end
    tick();
    total++; if ({bus1.rsp_valid, bus1.rsp_addr, bus1.rsp_data} !== {1'b1, 3'd1, 8'h77})
      $display("FAIL lat3_rsp got valid/addr/data=%b/%0d/%h want 1/1/77", bus1.rsp_valid, bus1.rsp_addr, bus1.rsp_data); else passed++;
    tick();
    total++; if ({bus1.rsp_valid, bus1.cmd_ready} !== 2'b01)
      $display("FAIL lat3_handshake got valid/rdy=%b want 01", {bus1.rsp_valid, bus1.cmd_ready}); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    mem0[3] = 8'h3C; mem0[1] = 8'h77;
    mem1[3] = 8'h3C; mem1[1] = 8'h77;
    bus0.cmd_valid = 1'b0; bus0.cmd_write = 1'b0; bus0.cmd_addr = '0; bus0.cmd_wdata = '0; bus0.rsp_ready = 1'b0;
    bus1.cmd_valid = 1'b0; bus1.cmd_write = 1'b0; bus1.cmd_addr = '0; bus1.cmd_wdata = '0; bus1.rsp_ready = 1'b0;
    #2;
    test_reset();
    test_write_read();
    test_backpressure();
    test_reset_mid_read();
    test_back_to_back();
    test_latency3();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_master.md
# mem_master

Bus initiator for the 8-entry × 8-bit memory bus (enable / rd_wr / addr / wr_data / rd_data / rst). It accepts read and write commands on a valid/ready command channel and drives one memory access per command. Read data is returned on a valid/ready response channel. It also sequences the memory's reset. It sits between any traffic source (test sequencer, CPU-side logic) and the memory, replacing the bench driver as the hardware owner of the bus.

## Interface
Parameters:
- ADDR_W, 3, memory address width
- DATA_W, 8, memory data width
- RD_LATENCY, 1, edges from the memory sampling a read to rd_data being valid (≥1)
- RST_CYCLES, 2, edges mem_rst stays high after rst release (≥1)

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  one clock; reset is asynchronous and active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  read response present
- rsp_ready  in  1  response consumed when high together with rsp_valid
- rsp_addr  out  ADDR_W  address of the returned read
- rsp_data  out  DATA_W  read data
- mem_rst  out  1  memory reset
- mem_enable  out  1  memory access strobe, one cycle per access
- mem_rd_wr  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_wr_data  out  DATA_W  memory write data
- mem_rd_data  in  DATA_W  memory read data
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- **FSM states:** RESET_HOLD, IDLE, READ_WAIT, RSP_HOLD.
- **cmd_ready:** equals (state == IDLE). It is a function of state only and never depends on cmd_valid.
- **All mem_* outputs are registered.**
  - Idle defaults: mem_enable = 0 and mem_rd_wr = 0.
  - mem_addr and mem_wr_data hold their last driven values.
- **RESET_HOLD:**
  - Entered asynchronously on rst.
  - mem_rst = 1; a counter clears to 0.
  - After rst falls, the counter increments each edge.
  - On the edge where counter == RST_CYCLES−1, the FSM goes to IDLE and mem_rst drops to 0.
- **IDLE, write accepted:**
  - Next cycle: mem_enable = 1, mem_rd_wr = 1, mem_addr = cmd_addr, mem_wr_data = cmd_wdata.
  - The FSM stays in IDLE, so back-to-back writes issue at one per cycle.
- **IDLE, read accepted:**
  - Next cycle: mem_enable = 1, mem_rd_wr = 0, mem_addr = cmd_addr.
  - The FSM goes to READ_WAIT with a latency counter loaded; the address is latched for rsp_addr.
- **READ_WAIT:**
  - mem_enable = 0.
  - After RD_LATENCY further edges, mem_rd_data is captured into rsp_data.
  - On that capture edge, rsp_valid rises and the FSM goes to RSP_HOLD.
- **RSP_HOLD:**
  - rsp_valid = 1; rsp_data and rsp_addr are held stable.
  - On rsp_valid && rsp_ready, rsp_valid falls and the FSM goes to IDLE.
- **Command acceptance:** no command is accepted during READ_WAIT or RSP_HOLD. There is at most one outstanding read.
- **Reset mid-operation:**
  - rst at any time forces RESET_HOLD immediately.
  - Any pending read response is discarded; mem_enable drops asynchronously.
- **Command fields:** widths pass straight through with no arithmetic. Unused command fields are don't-care.

## Timing
- **Reset values:**
  - mem_rst = 1.
  - cmd_ready, rsp_valid, mem_enable, mem_rd_wr, busy = 0.
  - mem_addr, mem_wr_data, rsp_addr, rsp_data = 0.
  - busy = 1 from the first edge in RESET_HOLD while rst is low.
- **Write:** accept at edge E0, then mem_enable is high for exactly the cycle between E0 and E1.
- **Read:**
  - Accept at E0; mem_enable is high for E0–E1 and the memory samples at E1.
  - rsp_valid rises after edge E(1+RD_LATENCY).
  - With RD_LATENCY = 1, rsp_valid is high after E2.
  - If rsp_ready is already high, the handshake occurs at E(2+RD_LATENCY) and cmd_ready is high again after that edge.
- **rsp_ready:** held low indefinitely, the FSM stays in RSP_HOLD with outputs stable and no mem_enable.
- **rst release:** cmd_ready first rises after edge RST_CYCLES counted from the first edge with rst low.

## Test plan
- **Reset release:** rst high 3 cycles then low, RST_CYCLES = 2 -> mem_rst high throughout rst and for 2 edges after; cmd_ready = 0 until then; all other outputs at their reset values.
- **Write then read-back:** write addr 5 data 0xA5, then read addr 5 with rsp_ready = 1 -> one mem_enable pulse with rd_wr = 1, then one with rd_wr = 0; rsp_valid appears 2 edges after the read accept with rsp_addr = 5, rsp_data = 0xA5.
- **Back-to-back writes:** addr 0..7, data 0x10+addr, cmd_valid held high -> 8 consecutive mem_enable cycles, rd_wr = 1, cmd_ready never drops, busy stays 0.
- **Response backpressure:** read addr 3 (holds 0x3C) with rsp_ready = 0 for 5 cycles -> rsp_valid high and rsp_data = 0x3C stable; cmd_ready = 0 and no mem_enable for those cycles; cmd_ready returns one edge after rsp_ready rises.
- **Reset mid-read:** assert rst during READ_WAIT -> rsp_valid never asserts; mem_enable = 0 and mem_rst = 1 immediately; after release, the first new read returns correct data.
- **RD_LATENCY = 3:** read addr 1 (holds 0x77) -> rsp_valid rises after edge E4 relative to accept edge E0, with rsp_data = 0x77.
